// File: rtl/pipe_sequencer.sv
// Pipeline stage-enable / flush sequencer for the F/D/E/M/W pipeline; optional perf counters under PIPE_PERF_CNT_EN.
// Latency: enables, flushes and mc_go are combinational from state and inputs; mc_err and halted come from registers.
// Backpressure: stalls F/D while a load-use hazard is present, holds F/D/E during multi-cycle ops, and freezes all stages on debug halt.
module pipe_sequencer #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             mc_start,
    input  logic             mc_done,
    input  logic             halt_req,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             bubble_m,
    output logic             mc_go,
    output logic             mc_err,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    // Last wait-counter value before abort: the MC_TIMEOUT-th wait cycle.
    localparam logic [7:0] TO_LAST = 8'(MC_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_to_cnt;
    logic [7:0] w_to_cnt_nxt;
    logic       r_mc_err;
    logic       w_timeout;

    // Next-state and per-stage controls; reset forces everything to flush/bubble.
    always_comb begin
        w_state_nxt  = r_state;
        w_to_cnt_nxt = r_to_cnt;
        w_timeout    = 1'b0;
        en_f         = 1'b1;
        en_d         = 1'b1;
        en_e         = 1'b1;
        en_m         = 1'b1;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        bubble_m     = 1'b0;
        mc_go        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (flush_in) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (mc_start) begin
                    mc_go        = 1'b1;
                    en_f         = 1'b0;
                    en_d         = 1'b0;
                    en_e         = 1'b0;
                    bubble_m     = 1'b1;
                    w_to_cnt_nxt = 8'd0;
                    w_state_nxt  = S_MC_WAIT;
                end else if (stall_in) begin
                    en_f    = 1'b0;
                    en_d    = 1'b0;
                    flush_e = 1'b1;
                end else if (halt_req) begin
                    w_state_nxt = S_HALTED;
                end
            end
            S_MC_WAIT: begin
                en_f         = 1'b0;
                en_d         = 1'b0;
                en_e         = 1'b0;
                bubble_m     = 1'b1;
                w_to_cnt_nxt = r_to_cnt + 8'd1;
                if (mc_done) begin
                    // Result leaves E this cycle; the front end advances with it.
                    en_f        = 1'b1;
                    en_d        = 1'b1;
                    en_e        = 1'b1;
                    bubble_m    = 1'b0;
                    w_state_nxt = S_RUN;
                end else if (r_to_cnt == TO_LAST) begin
                    // Abort: drop the stuck op out of E and resume.
                    flush_e     = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_HALTED: begin
                en_f = 1'b0;
                en_d = 1'b0;
                en_e = 1'b0;
                en_m = 1'b0;
                if (!halt_req) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
        if (rst) begin
            en_f      = 1'b0;
            en_d      = 1'b0;
            en_e      = 1'b0;
            en_m      = 1'b0;
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            bubble_m  = 1'b1;
            mc_go     = 1'b0;
            w_timeout = 1'b0;
        end
    end

    // State, wait counter and the delayed abort pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_RUN;
            r_to_cnt <= 8'd0;
            r_mc_err <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_to_cnt <= w_to_cnt_nxt;
            r_mc_err <= w_timeout;
        end
    end

    assign mc_err = r_mc_err;
    assign halted = (r_state == S_HALTED) && !rst;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Saturating perf counters: frozen-fetch cycles and accepted flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!en_f && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if ((r_state == S_RUN) && flush_in && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
